// File: rtl/tdp_ram_clr_if.sv
`default_nettype none
// =============================================================================
// tdp_ram_clr_if : port bundle of the self-clearing true dual-port RAM
// Rev 1.0
// =============================================================================
interface tdp_ram_clr_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  en_a;
    logic                  we_a;
    logic [BE_WIDTH-1:0]   be_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] data_a;
    logic [DATA_WIDTH-1:0] q_a;
    logic                  valid_a;

    logic                  en_b;
    logic                  we_b;
    logic [BE_WIDTH-1:0]   be_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] data_b;
    logic [DATA_WIDTH-1:0] q_b;
    logic                  valid_b;

    logic                  ready;
    logic                  collision;
    logic [15:0]           coll_count;

    modport master (
        output en_a, we_a, be_a, addr_a, data_a,
        output en_b, we_b, be_b, addr_b, data_b,
        input  q_a, valid_a, q_b, valid_b, ready, collision, coll_count
    );

    modport slave (
        input  en_a, we_a, be_a, addr_a, data_a,
        input  en_b, we_b, be_b, addr_b, data_b,
        output q_a, valid_a, q_b, valid_b, ready, collision, coll_count
    );
endinterface
`default_nettype wire

// File: rtl/tdp_ram_clr.sv
`default_nettype none
// =============================================================================
// tdp_ram_clr : true dual-port RAM with byte enables, collision policy and self-clear
// Rev 1.0
// =============================================================================
module tdp_ram_clr #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    tdp_ram_clr_if.slave  bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH    = 1 << ADDR_WIDTH;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q;
    logic                  run, clearing;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  acc_a, acc_b, wr_a, wr_b, same_addr, coll;
    logic [DATA_WIDTH-1:0] old_a, old_b, res_a, res_b, rd_a, rd_b;

    logic [DATA_WIDTH-1:0] q1_a_q, q1_b_q;
    logic                  v1_a_q, v1_b_q;
    logic                  coll_q;
    logic [15:0]           coll_cnt_q;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (clearing) begin
                clr_ptr_q <= clr_ptr_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (&clr_ptr_q) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        run      = (state_q == S_RUN);
        clearing = (state_q == S_CLEAR);
    end

    // ---------------- access decode ----------------
    always_comb begin
        acc_a     = run & bus.en_a;
        acc_b     = run & bus.en_b;
        wr_a      = acc_a & bus.we_a;
        wr_b      = acc_b & bus.we_b;
        same_addr = (bus.addr_a == bus.addr_b);
        coll      = wr_a & wr_b & same_addr;
        old_a     = mem_q[bus.addr_a];
        old_b     = mem_q[bus.addr_b];
    end

    // Post-edge word seen by each writer; port A bytes win on a shared address.
    always_comb begin
        res_a = old_a;
        res_b = old_b;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (wr_b && same_addr && bus.be_b[i]) res_a[8*i +: 8] = bus.data_b[8*i +: 8];
            if (wr_a && bus.be_a[i])              res_a[8*i +: 8] = bus.data_a[8*i +: 8];
            if (wr_b && bus.be_b[i])              res_b[8*i +: 8] = bus.data_b[8*i +: 8];
            if (wr_a && same_addr && bus.be_a[i]) res_b[8*i +: 8] = bus.data_a[8*i +: 8];
        end
        // A pure reader always sees pre-write contents, even in write-first mode.
        rd_a = (RDW_MODE != 0 && wr_a) ? res_a : old_a;
        rd_b = (RDW_MODE != 0 && wr_b) ? res_b : old_b;
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clearing) begin
                mem_q[clr_ptr_q] <= '0;
            end
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (wr_b && bus.be_b[i]) mem_q[bus.addr_b][8*i +: 8] <= bus.data_b[8*i +: 8];
                if (wr_a && bus.be_a[i]) mem_q[bus.addr_a][8*i +: 8] <= bus.data_a[8*i +: 8];
            end
        end
    end

    // ---------------- read stage and collision tracking ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            q1_a_q     <= '0;
            q1_b_q     <= '0;
            v1_a_q     <= 1'b0;
            v1_b_q     <= 1'b0;
            coll_q     <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            v1_a_q <= acc_a;
            v1_b_q <= acc_b;
            if (acc_a) q1_a_q <= rd_a;
            if (acc_b) q1_b_q <= rd_b;
            coll_q <= coll;
            if (coll && coll_cnt_q != 16'hFFFF) begin
                coll_cnt_q <= coll_cnt_q + 16'd1;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] q2_a_q, q2_b_q;
            logic                  v2_a_q, v2_b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    q2_a_q <= '0;
                    q2_b_q <= '0;
                    v2_a_q <= 1'b0;
                    v2_b_q <= 1'b0;
                end else begin
                    v2_a_q <= v1_a_q;
                    v2_b_q <= v1_b_q;
                    if (v1_a_q) q2_a_q <= q1_a_q;
                    if (v1_b_q) q2_b_q <= q1_b_q;
                end
            end

            assign bus.q_a     = q2_a_q;
            assign bus.q_b     = q2_b_q;
            assign bus.valid_a = v2_a_q;
            assign bus.valid_b = v2_b_q;
        end else begin : g_no_out_reg
            assign bus.q_a     = q1_a_q;
            assign bus.q_b     = q1_b_q;
            assign bus.valid_a = v1_a_q;
            assign bus.valid_b = v1_b_q;
        end
    endgenerate

    assign bus.ready      = run;
    assign bus.collision  = coll_q;
    assign bus.coll_count = coll_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_tdp_ram_clr.sv
`default_nettype none
// =============================================================================
// tb_tdp_ram_clr : scoreboard bench, 8-bit read-first and 16-bit write-first/out-reg
// Rev 1.0
// =============================================================================
module tb_tdp_ram_clr;
    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst0, rst1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    exp_t sb0a[$], sb0b[$], sb1a[$], sb1b[$];
    exp_t e0a, e0b, e1a, e1b;

    tdp_ram_clr_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(6)) bus0 ();
    tdp_ram_clr_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) bus1 ();

    tdp_ram_clr #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RDW_MODE(0), .OUT_REG(0)) dut0 (
        .clk(clk), .rst(rst0), .bus(bus0.slave));
    tdp_ram_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .RDW_MODE(1), .OUT_REG(1)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-result scoreboards: every valid must match the oldest expectation on its due cycle.
    always @(negedge clk) begin
        if (bus0.valid_a === 1'b1) begin
            total++;
            if (sb0a.size() == 0) begin
                bad++; $display("FAIL mon0a: unexpected valid q=%h cyc=%0d", bus0.q_a, cyc);
            end else begin
                e0a = sb0a.pop_front();
                if (bus0.q_a !== e0a.data[7:0] || cyc != e0a.due) begin
                    bad++; $display("FAIL mon0a: q=%h at cyc %0d, want %h at cyc %0d", bus0.q_a, cyc, e0a.data[7:0], e0a.due);
                end
            end
        end else if (sb0a.size() != 0 && sb0a[0].due <= cyc) begin
            total++; bad++;
            $display("FAIL mon0a: no valid at cyc %0d, want %h due %0d", cyc, sb0a[0].data[7:0], sb0a[0].due);
            void'(sb0a.pop_front());
        end
        if (bus0.valid_b === 1'b1) begin
            total++;
            if (sb0b.size() == 0) begin
                bad++; $display("FAIL mon0b: unexpected valid q=%h cyc=%0d", bus0.q_b, cyc);
            end else begin
                e0b = sb0b.pop_front();
                if (bus0.q_b !== e0b.data[7:0] || cyc != e0b.due) begin
                    bad++; $display("FAIL mon0b: q=%h at cyc %0d, want %h at cyc %0d", bus0.q_b, cyc, e0b.data[7:0], e0b.due);
                end
            end
        end else if (sb0b.size() != 0 && sb0b[0].due <= cyc) begin
            total++; bad++;
            $display("FAIL mon0b: no valid at cyc %0d, want %h due %0d", cyc, sb0b[0].data[7:0], sb0b[0].due);
            void'(sb0b.pop_front());
        end
        if (bus1.valid_a === 1'b1) begin
            total++;
            if (sb1a.size() == 0) begin
                bad++; $display("FAIL mon1a: unexpected valid q=%h cyc=%0d", bus1.q_a, cyc);
            end else begin
                e1a = sb1a.pop_front();
                if (bus1.q_a !== e1a.data || cyc != e1a.due) begin
                    bad++; $display("FAIL mon1a: q=%h at cyc %0d, want %h at cyc %0d", bus1.q_a, cyc, e1a.data, e1a.due);
                end
            end
        end else if (sb1a.size() != 0 && sb1a[0].due <= cyc) begin
            total++; bad++;
            $display("FAIL mon1a: no valid at cyc %0d, want %h due %0d", cyc, sb1a[0].data, sb1a[0].due);
            void'(sb1a.pop_front());
        end
        if (bus1.valid_b === 1'b1) begin
            total++;
            if (sb1b.size() == 0) begin
                bad++; $display("FAIL mon1b: unexpected valid q=%h cyc=%0d", bus1.q_b, cyc);
            end else begin
                e1b = sb1b.pop_front();
                if (bus1.q_b !== e1b.data || cyc != e1b.due) begin
                    bad++; $display("FAIL mon1b: q=%h at cyc %0d, want %h at cyc %0d", bus1.q_b, cyc, e1b.data, e1b.due);
                end
            end
        end else if (sb1b.size() != 0 && sb1b[0].due <= cyc) begin
            total++; bad++;
            $display("FAIL mon1b: no valid at cyc %0d, want %h due %0d", cyc, sb1b[0].data, sb1b[0].due);
            void'(sb1b.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        bus0.en_a = 0; bus0.we_a = 0; bus0.be_a = '0; bus0.addr_a = '0; bus0.data_a = '0;
        bus0.en_b = 0; bus0.we_b = 0; bus0.be_b = '0; bus0.addr_b = '0; bus0.data_b = '0;
    endtask

    task automatic idle1();
        bus1.en_a = 0; bus1.we_a = 0; bus1.be_a = '0; bus1.addr_a = '0; bus1.data_a = '0;
        bus1.en_b = 0; bus1.we_b = 0; bus1.be_b = '0; bus1.addr_b = '0; bus1.data_b = '0;
    endtask

    task automatic test_reset();
        idle0(); idle1();
        rst0 = 1; rst1 = 1;
        tick(1);
        total++;
        if ({bus0.q_a, bus0.q_b, bus0.valid_a, bus0.valid_b, bus0.ready, bus0.collision, bus0.coll_count} !== '0) begin
            bad++; $display("FAIL reset0: outputs=%h want 0", {bus0.q_a, bus0.q_b, bus0.valid_a, bus0.valid_b, bus0.ready, bus0.collision, bus0.coll_count});
        end
        total++;
        if ({bus1.q_a, bus1.q_b, bus1.valid_a, bus1.valid_b, bus1.ready, bus1.collision, bus1.coll_count} !== '0) begin
            bad++; $display("FAIL reset1: outputs=%h want 0", {bus1.q_a, bus1.q_b, bus1.valid_a, bus1.valid_b, bus1.ready, bus1.collision, bus1.coll_count});
        end
        rst0 = 0; rst1 = 0;
        bus0.en_a = 1; bus0.addr_a = 6'h3F;
        for (int k = 0; k < 64; k++) begin
            total++;
            if (bus0.ready !== 1'b0 || bus1.ready !== 1'b0) begin
                bad++; $display("FAIL clear_ready: clear cycle %0d ready0=%b ready1=%b want 0", k, bus0.ready, bus1.ready);
            end
            tick(1);
        end
        total++;
        if (bus0.ready !== 1'b1 || bus1.ready !== 1'b1) begin
            bad++; $display("FAIL ready_rise: ready0=%b ready1=%b want 1", bus0.ready, bus1.ready);
        end
        sb0a.push_back(exp_t'{16'h0000, cyc + 1});
        tick(1);
        bus0.en_a = 0;
        tick(1);
    endtask

    task automatic test_basic();
        bus0.en_a = 1; bus0.we_a = 1; bus0.be_a = 1'b1; bus0.addr_a = 6'h01; bus0.data_a = 8'h33;
        bus0.en_b = 1; bus0.we_b = 1; bus0.be_b = 1'b1; bus0.addr_b = 6'h02; bus0.data_b = 8'h44;
        sb0a.push_back(exp_t'{16'h0000, cyc + 1});
        sb0b.push_back(exp_t'{16'h0000, cyc + 1});
        tick(1);
        total++;
        if (bus0.collision !== 1'b0) begin
            bad++; $display("FAIL basic_coll: collision=%b want 0", bus0.collision);
        end
        bus0.we_a = 0; bus0.addr_a = 6'h02;
        bus0.we_b = 0; bus0.addr_b = 6'h01;
        sb0a.push_back(exp_t'{16'h0044, cyc + 1});
        sb0b.push_back(exp_t'{16'h0033, cyc + 1});
        tick(1);
        idle0();
        tick(1);
    endtask

    task automatic test_rdw();
        // read-first instance
        bus0.en_a = 1; bus0.we_a = 1; bus0.be_a = 1'b1; bus0.addr_a = 6'h05; bus0.data_a = 8'hAA;
        sb0a.push_back(exp_t'{16'h0000, cyc + 1});
        tick(1);
        bus0.data_a = 8'h55;
        bus0.en_b = 1; bus0.we_b = 0; bus0.addr_b = 6'h05;
        sb0a.push_back(exp_t'{16'h00AA, cyc + 1});
        sb0b.push_back(exp_t'{16'h00AA, cyc + 1});
        tick(1);
        bus0.en_b = 0; bus0.be_a = 1'b0; bus0.data_a = 8'hFF;
        sb0a.push_back(exp_t'{16'h0055, cyc + 1});
        tick(1);
        bus0.we_a = 0;
        sb0a.push_back(exp_t'{16'h0055, cyc + 1});
        tick(1);
        idle0();
        tick(2);
        total++;
        if (bus0.q_a !== 8'h55 || bus0.valid_a !== 1'b0) begin
            bad++; $display("FAIL hold_q: q_a=%h valid_a=%b want 55/0", bus0.q_a, bus0.valid_a);
        end
        // write-first instance
        bus1.en_a = 1; bus1.we_a = 1; bus1.be_a = 2'b11; bus1.addr_a = 6'h05; bus1.data_a = 16'h00AA;
        sb1a.push_back(exp_t'{16'h00AA, cyc + 2});
        tick(1);
        bus1.data_a = 16'h0055;
        bus1.en_b = 1; bus1.we_b = 0; bus1.addr_b = 6'h05;
        sb1a.push_back(exp_t'{16'h0055, cyc + 2});
        sb1b.push_back(exp_t'{16'h00AA, cyc + 2});
        tick(1);
        idle1();
        tick(3);
    endtask

    task automatic test_byte_coll();
        bus1.en_a = 1; bus1.we_a = 1; bus1.be_a = 2'b01; bus1.addr_a = 6'h07; bus1.data_a = 16'h1234;
        bus1.en_b = 1; bus1.we_b = 1; bus1.be_b = 2'b11; bus1.addr_b = 6'h07; bus1.data_b = 16'hABCD;
        sb1a.push_back(exp_t'{16'hAB34, cyc + 2});
        sb1b.push_back(exp_t'{16'hAB34, cyc + 2});
        tick(1);
        total++;
        if (bus1.collision !== 1'b1 || bus1.coll_count !== 16'd1) begin
            bad++; $display("FAIL coll_pulse: collision=%b count=%0d want 1/1", bus1.collision, bus1.coll_count);
        end
        idle1();
        bus1.en_a = 1; bus1.addr_a = 6'h07;
        sb1a.push_back(exp_t'{16'hAB34, cyc + 2});
        tick(1);
        total++;
        if (bus1.collision !== 1'b0 || bus1.coll_count !== 16'd1) begin
            bad++; $display("FAIL coll_end: collision=%b count=%0d want 0/1", bus1.collision, bus1.coll_count);
        end
        idle1();
        tick(3);
    endtask

    task automatic test_outreg_reset();
        logic [5:0]  ad [4];
        logic [15:0] ex [4];
        int          err;
        ad = '{6'h05, 6'h07, 6'h01, 6'h05};
        ex = '{16'h0055, 16'hAB34, 16'h0000, 16'h0055};
        for (int i = 0; i < 4; i++) begin
            bus1.en_a = 1; bus1.we_a = 0; bus1.addr_a = ad[i];
            sb1a.push_back(exp_t'{ex[i], cyc + 2});
            tick(1);
        end
        rst1 = 1;
        tick(1);
        sb1a.delete();
        total++;
        if (bus1.valid_a !== 1'b0 || bus1.q_a !== 16'h0000 || bus1.ready !== 1'b0 || bus1.coll_count !== 16'd0) begin
            bad++; $display("FAIL midrst: valid_a=%b q_a=%h ready=%b count=%0d want 0/0/0/0", bus1.valid_a, bus1.q_a, bus1.ready, bus1.coll_count);
        end
        rst1 = 0;
        err = 0;
        for (int k = 0; k < 64; k++) begin
            if (bus1.ready !== 1'b0) err++;
            tick(1);
        end
        total++;
        if (err != 0 || bus1.ready !== 1'b1) begin
            bad++; $display("FAIL reclear: early ready cycles=%0d final ready=%b want 0/1", err, bus1.ready);
        end
        bus1.addr_a = 6'h07;
        sb1a.push_back(exp_t'{16'h0000, cyc + 2});
        tick(1);
        idle1();
        tick(3);
    endtask

    task automatic test_saturation();
        int          perr;
        int          fk;
        logic [15:0] exp_cnt, fcnt;
        perr = 0; fk = -1; fcnt = '0;
        bus0.en_a = 1; bus0.we_a = 1; bus0.be_a = 1'b1; bus0.addr_a = 6'h10; bus0.data_a = 8'h5A;
        bus0.en_b = 1; bus0.we_b = 1; bus0.be_b = 1'b1; bus0.addr_b = 6'h10; bus0.data_b = 8'hC3;
        for (int k = 0; k < 65537; k++) begin
            sb0a.push_back(exp_t'{(k == 0) ? 16'h0000 : 16'h005A, cyc + 1});
            sb0b.push_back(exp_t'{(k == 0) ? 16'h0000 : 16'h005A, cyc + 1});
            tick(1);
            exp_cnt = (k + 1 > 65535) ? 16'hFFFF : 16'(k + 1);
            if (bus0.collision !== 1'b1 || bus0.coll_count !== exp_cnt) begin
                if (fk < 0) begin fk = k; fcnt = bus0.coll_count; end
                perr++;
            end
        end
        total++;
        if (perr != 0) begin
            bad++; $display("FAIL sat_run: %0d bad cycles, first at collision %0d count=%h", perr, fk + 1, fcnt);
        end
        idle0();
        tick(1);
        total++;
        if (bus0.collision !== 1'b0 || bus0.coll_count !== 16'hFFFF) begin
            bad++; $display("FAIL sat_hold: collision=%b count=%h want 0/FFFF", bus0.collision, bus0.coll_count);
        end
        tick(1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] m [8];
        int         cnt, w;
        logic       ea, eb, wa, wb, ba, bb, coll;
        logic [2:0] aa, ab;
        logic [7:0] da, db;
        rst0 = 1;
        tick(1);
        rst0 = 0;
        w = 0;
        while (bus0.ready !== 1'b1 && w < 100) begin
            tick(1);
            w++;
        end
        total++;
        if (w != 64) begin
            bad++; $display("FAIL reclear0: ready after %0d cycles want 64", w);
        end
        for (int i = 0; i < 8; i++) m[i] = 8'h00;
        cnt = 0;
        for (int n = 0; n < 300; n++) begin
            ea = 1'($urandom_range(0, 3) != 0); eb = 1'($urandom_range(0, 3) != 0);
            wa = 1'($urandom_range(0, 1));      wb = 1'($urandom_range(0, 1));
            ba = 1'($urandom_range(0, 3) != 0); bb = 1'($urandom_range(0, 3) != 0);
            aa = 3'($urandom_range(0, 7));      ab = 3'($urandom_range(0, 7));
            da = 8'($urandom);                  db = 8'($urandom);
            bus0.en_a = ea; bus0.we_a = wa; bus0.be_a = ba; bus0.addr_a = {3'b000, aa}; bus0.data_a = da;
            bus0.en_b = eb; bus0.we_b = wb; bus0.be_b = bb; bus0.addr_b = {3'b000, ab}; bus0.data_b = db;
            if (ea) sb0a.push_back(exp_t'{{8'h00, m[aa]}, cyc + 1});
            if (eb) sb0b.push_back(exp_t'{{8'h00, m[ab]}, cyc + 1});
            coll = ea & wa & eb & wb & (aa == ab);
            if (eb && wb && bb) m[ab] = db;
            if (ea && wa && ba) m[aa] = da;
            if (coll) cnt++;
            tick(1);
            total++;
            if (bus0.collision !== coll || bus0.coll_count !== 16'(cnt)) begin
                bad++; $display("FAIL b2b_coll: step %0d collision=%b count=%0d want %b/%0d", n, bus0.collision, bus0.coll_count, coll, cnt);
            end
        end
        idle0();
        for (int i = 0; i < 8; i++) begin
            bus0.en_b = 1; bus0.addr_b = 6'(i);
            sb0b.push_back(exp_t'{{8'h00, m[i]}, cyc + 1});
            tick(1);
        end
        idle0();
        tick(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rdw();
        test_byte_coll();
        test_outreg_reset();
        test_saturation();
        test_back_to_back();
        tick(3);
        total++;
        if (sb0a.size() + sb0b.size() + sb1a.size() + sb1b.size() != 0) begin
            bad++; $display("FAIL drain: %0d reads never returned, want 0", sb0a.size() + sb0b.size() + sb1a.size() + sb1b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
